// File: rtl/axi_slave_mem.sv
// AXI memory slave endpoint: independent write (AW/W/B) and read (AR/R) burst engines
// over a byte-strobed 32-bit word array, with window decode and request legality checks.
module axi_slave_mem #(
    parameter int unsigned ID_W      = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ID_W-1:0] s_awid,
    input  logic [31:0]     s_awaddr,
    input  logic [3:0]      s_awlen,
    input  logic [2:0]      s_awsize,
    input  logic [1:0]      s_awburst,
    input  logic            s_awvalid,
    output logic            s_awready,
    input  logic [31:0]     s_wdata,
    input  logic [3:0]      s_wstrb,
    input  logic            s_wlast,
    input  logic            s_wvalid,
    output logic            s_wready,
    output logic [ID_W-1:0] s_bid,
    output logic [1:0]      s_bresp,
    output logic            s_bvalid,
    input  logic            s_bready,
    input  logic [ID_W-1:0] s_arid,
    input  logic [31:0]     s_araddr,
    input  logic [3:0]      s_arlen,
    input  logic [2:0]      s_arsize,
    input  logic [1:0]      s_arburst,
    input  logic            s_arvalid,
    output logic            s_arready,
    output logic [ID_W-1:0] s_rid,
    output logic [31:0]     s_rdata,
    output logic [1:0]      s_rresp,
    output logic            s_rlast,
    output logic            s_rvalid,
    input  logic            s_rready
);

    localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [31:0] r_mem [MEM_WORDS];

    function automatic logic f_illegal(input logic [2:0] size, input logic [1:0] burst,
                                       input logic [3:0] len);
        logic wrap_bad;
        wrap_bad = (burst == 2'd2) &&
                   !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
        return (size != 3'd2) || (burst == 2'd3) || wrap_bad;
    endfunction

    // Next beat offset; INCR wraps the word index inside the window, WRAP inside (len+1) words.
    function automatic logic [31:0] f_next_off(input logic [31:0] off, input logic [3:0] len,
                                               input logic [1:0] burst);
        logic [29:0] w;
        logic [29:0] m;
        w = off[31:2];
        m = 30'(len);
        case (burst)
            2'd0:    return off;
            2'd2:    return {(w & ~m) | ((w + 30'd1) & m), 2'b00};
            default: return {off[31:IDX_W+2], off[IDX_W+1:2] + IDX_W'(1), 2'b00};
        endcase
    endfunction

    // ---------------- write channel ----------------
    w_state_t        r_w_state, w_w_state_nxt;
    logic            r_awready, r_wready, r_bvalid;
    logic [ID_W-1:0] r_bid, r_wid;
    logic [1:0]      r_bresp, r_wacc, r_wburst;
    logic [31:0]     r_woff;
    logic [3:0]      r_wlen, r_wbeat;
    logic            r_wbad;

    logic            w_aw_hs, w_w_hs, w_b_hs, w_wr_last, w_wr_dec;
    logic [1:0]      w_wr_beat_resp, w_wr_acc_nxt;
    logic [IDX_W-1:0] w_wr_idx;

    assign s_awready = r_awready;
    assign s_wready  = r_wready;
    assign s_bvalid  = r_bvalid;
    assign s_bid     = r_bid;
    assign s_bresp   = r_bresp;

    assign w_aw_hs   = r_awready & s_awvalid;
    assign w_w_hs    = r_wready & s_wvalid;
    assign w_b_hs    = r_bvalid & s_bready;
    assign w_wr_last = (r_wbeat == r_wlen);
    assign w_wr_dec  = (r_woff >= WIN_BYTES);
    assign w_wr_idx  = r_woff[IDX_W+1:2];
    assign w_wr_beat_resp = w_wr_dec ? RESP_DECERR :
                            (s_wlast != w_wr_last) ? RESP_SLVERR : RESP_OKAY;
    // Response codes order numerically by severity, so worst-of is a max.
    assign w_wr_acc_nxt = (w_wr_beat_resp > r_wacc) ? w_wr_beat_resp : r_wacc;

    always_comb begin
        w_w_state_nxt = r_w_state;
        case (r_w_state)
            W_IDLE:  if (w_aw_hs) w_w_state_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wr_last) w_w_state_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_w_state_nxt = W_IDLE;
            default: w_w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_awready <= (w_w_state_nxt == W_IDLE);
            r_wready  <= (w_w_state_nxt == W_DATA);
            r_bvalid  <= (w_w_state_nxt == W_RESP);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
            r_wid    <= '0;
            r_woff   <= '0;
            r_wlen   <= '0;
            r_wburst <= '0;
            r_wbad   <= 1'b0;
            r_wbeat  <= '0;
            r_wacc   <= RESP_OKAY;
        end else begin
            if (w_aw_hs) begin
                r_wid    <= s_awid;
                r_woff   <= (s_awaddr - BASE_ADDR) & ~32'd3;
                r_wlen   <= s_awlen;
                r_wburst <= s_awburst;
                r_wbad   <= f_illegal(s_awsize, s_awburst, s_awlen);
                r_wbeat  <= '0;
                r_wacc   <= f_illegal(s_awsize, s_awburst, s_awlen) ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_w_hs) begin
                r_woff  <= f_next_off(r_woff, r_wlen, r_wburst);
                r_wbeat <= r_wbeat + 4'd1;
                r_wacc  <= w_wr_acc_nxt;
                if (w_wr_last) begin
                    r_bid   <= r_wid;
                    r_bresp <= w_wr_acc_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn && w_w_hs && !w_wr_dec && !r_wbad) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    r_state_t        r_r_state, w_r_state_nxt;
    logic            r_arready, r_rvalid, r_rlast, r_rbad;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_rdata, r_roff;
    logic [1:0]      r_rresp, r_rburst;
    logic [3:0]      r_rlen, r_rbeat;

    logic            w_ar_hs, w_r_hs, w_ld, w_ld_bad, w_ld_dec;
    logic [31:0]     w_ar_off, w_rnext_off, w_ld_off;

    assign s_arready = r_arready;
    assign s_rvalid  = r_rvalid;
    assign s_rid     = r_rid;
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign s_rlast   = r_rlast;

    assign w_ar_hs     = r_arready & s_arvalid;
    assign w_r_hs      = r_rvalid & s_rready;
    assign w_ar_off    = (s_araddr - BASE_ADDR) & ~32'd3;
    assign w_rnext_off = f_next_off(r_roff, r_rlen, r_rburst);
    assign w_ld        = w_ar_hs | (w_r_hs & ~r_rlast);
    assign w_ld_off    = w_ar_hs ? w_ar_off : w_rnext_off;
    assign w_ld_bad    = w_ar_hs ? f_illegal(s_arsize, s_arburst, s_arlen) : r_rbad;
    assign w_ld_dec    = (w_ld_off >= WIN_BYTES);

    always_comb begin
        w_r_state_nxt = r_r_state;
        case (r_r_state)
            R_IDLE:  if (w_ar_hs) w_r_state_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast) w_r_state_nxt = R_IDLE;
            default: w_r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arready <= (w_r_state_nxt == R_IDLE);
            r_rvalid  <= (w_r_state_nxt == R_DATA);
        end
    end

    // Beat data is fetched on the AR handshake or on a non-final R handshake, so it holds under stall.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rlast  <= 1'b0;
            r_roff   <= '0;
            r_rlen   <= '0;
            r_rburst <= '0;
            r_rbad   <= 1'b0;
            r_rbeat  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rid    <= s_arid;
                r_rlen   <= s_arlen;
                r_rburst <= s_arburst;
                r_rbeat  <= '0;
                r_rlast  <= (s_arlen == 4'd0);
            end else if (w_ld) begin
                r_rbeat  <= r_rbeat + 4'd1;
                r_rlast  <= ((r_rbeat + 4'd1) == r_rlen);
            end else if (w_r_hs) begin
                r_rlast  <= 1'b0;
            end
            if (w_ld) begin
                r_roff  <= w_ld_off;
                r_rbad  <= w_ld_bad;
                r_rresp <= w_ld_dec ? RESP_DECERR : (w_ld_bad ? RESP_SLVERR : RESP_OKAY);
                r_rdata <= (w_ld_dec || w_ld_bad) ? 32'd0 : r_mem[w_ld_off[IDX_W+1:2]];
            end
        end
    end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: one task per scenario with hand-computed expectations.
module tb_axi_slave_mem;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [3:0]  s_awlen, s_arlen, s_wstrb;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

    int checks = 0;
    int passed = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    logic        wr_last [16];
    logic [5:0]  wr_bid;
    logic [1:0]  wr_bresp;
    logic        wr_bok;
    int          wr_beats;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [5:0]  rd_id   [16];
    int          rd_cnt, rd_stalls, rd_unstable, rd_cycles;
    logic        rd_first_valid, rd_arready_after;

    always #5 clk = ~clk;

    axi_slave_mem #(.ID_W(6), .BASE_ADDR(32'h0), .MEM_WORDS(1024)) dut (
        .clk(clk), .rstn(rstn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
        .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prep_write(input int len);
        for (int i = 0; i < 16; i++) begin
            wr_data[i] = 32'd0;
            wr_strb[i] = 4'hF;
            wr_last[i] = (i == len);
        end
    endtask

    task automatic do_write(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 50) begin cyc(); n++; end
        cyc();
        s_awvalid = 1'b0;
        wr_beats = 0;
        for (int i = 0; i <= int'(len); i++) begin
            s_wvalid = 1'b1; s_wdata = wr_data[i]; s_wstrb = wr_strb[i]; s_wlast = wr_last[i];
            n = 0;
            while (!s_wready && n < 50) begin cyc(); n++; end
            if (s_wready) wr_beats++;
            cyc();
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s_bready = 1'b1;
        n = 0;
        while (!s_bvalid && n < 50) begin cyc(); n++; end
        wr_bok = s_bvalid; wr_bid = s_bid; wr_bresp = s_bresp;
        cyc();
        s_bready = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        int n, cnt;
        bit stall_prev;
        logic [31:0] pd;
        logic [1:0]  pr;
        logic        pl;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin cyc(); n++; end
        cyc();
        s_arvalid = 1'b0;
        rd_first_valid = s_rvalid;
        cnt = 0; n = 0; stall_prev = 0; rd_stalls = 0; rd_unstable = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (cnt <= int'(len) && n < 200) begin
            if (stall_prev) begin
                if (!(s_rvalid === 1'b1 && s_rdata === pd && s_rresp === pr && s_rlast === pl))
                    rd_unstable++;
                stall_prev = 0;
            end
            s_rready = toggle ? ((n % 2) == 0) : 1'b1;
            if (s_rvalid && s_rready) begin
                rd_data[cnt] = s_rdata; rd_resp[cnt] = s_rresp;
                rd_last[cnt] = s_rlast; rd_id[cnt] = s_rid;
                cnt++;
            end else if (s_rvalid) begin
                stall_prev = 1; pd = s_rdata; pr = s_rresp; pl = s_rlast;
                rd_stalls++;
            end
            cyc();
            n++;
        end
        s_rready = 1'b0;
        rd_cnt = cnt; rd_cycles = n; rd_arready_after = s_arready;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        repeat (3) cyc();
        checks++; if (s_awready !== 1'b1 || s_arready !== 1'b1) $display("FAIL reset_ready: aw=%b ar=%b expected 1 1", s_awready, s_arready); else passed++;
        checks++; if ({s_wready, s_bvalid, s_rvalid, s_rlast} !== 4'b0) $display("FAIL reset_valids: w/b/rv/rl=%b expected 0000", {s_wready, s_bvalid, s_rvalid, s_rlast}); else passed++;
        checks++; if (s_bid !== 6'd0 || s_rid !== 6'd0 || s_bresp !== 2'd0 || s_rresp !== 2'd0 || s_rdata !== 32'd0)
            $display("FAIL reset_fields: bid=%h rid=%h bresp=%b rresp=%b rdata=%h expected zeros", s_bid, s_rid, s_bresp, s_rresp, s_rdata); else passed++;
        rstn = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        prep_write(0);
        wr_data[0] = 32'hDEADBEEF;
        do_write(6'h05, 32'h10, 4'd0, 3'd2, 2'd1);
        checks++; if (wr_bok !== 1'b1 || wr_bid !== 6'h05 || wr_bresp !== 2'b00) $display("FAIL single_b: ok=%b bid=%h bresp=%b expected 1 05 00", wr_bok, wr_bid, wr_bresp); else passed++;
        checks++; if (s_awready !== 1'b1) $display("FAIL single_awready_after_b: got %b expected 1", s_awready); else passed++;
        do_read(6'h05, 32'h10, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_first_valid !== 1'b1) $display("FAIL single_r_latency: rvalid=%b expected 1", rd_first_valid); else passed++;
        checks++; if (rd_cnt != 1 || rd_data[0] !== 32'hDEADBEEF || rd_last[0] !== 1'b1 || rd_id[0] !== 6'h05 || rd_resp[0] !== 2'b00)
            $display("FAIL single_r: cnt=%0d data=%h last=%b id=%h resp=%b expected 1 deadbeef 1 05 00", rd_cnt, rd_data[0], rd_last[0], rd_id[0], rd_resp[0]); else passed++;
        checks++; if (rd_arready_after !== 1'b1) $display("FAIL single_arready_after: got %b expected 1", rd_arready_after); else passed++;
    endtask

    task automatic test_incr_stall();
        prep_write(3);
        for (int i = 0; i < 4; i++) wr_data[i] = 32'(i + 1);
        do_write(6'h11, 32'h40, 4'd3, 3'd2, 2'd1);
        checks++; if (wr_bok !== 1'b1 || wr_bresp !== 2'b00 || wr_bid !== 6'h11) $display("FAIL incr_b: ok=%b bid=%h bresp=%b expected 1 11 00", wr_bok, wr_bid, wr_bresp); else passed++;
        do_read(6'h22, 32'h40, 4'd3, 3'd2, 2'd1, 1'b1);
        checks++; if (rd_cnt != 4) $display("FAIL incr_beats: got %0d expected 4", rd_cnt); else passed++;
        for (int i = 0; i < 4; i++) begin
            checks++; if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3) || rd_id[i] !== 6'h22)
                $display("FAIL incr_beat%0d: data=%h last=%b id=%h expected %h %b 22", i, rd_data[i], rd_last[i], rd_id[i], i + 1, i == 3); else passed++;
        end
        checks++; if (rd_stalls != 3 || rd_unstable != 0) $display("FAIL incr_stall: stalls=%0d unstable=%0d expected 3 0", rd_stalls, rd_unstable); else passed++;
    endtask

    task automatic test_wrap();
        prep_write(3);
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; wr_data[2] = 32'hC; wr_data[3] = 32'hD;
        do_write(6'h01, 32'h30, 4'd3, 3'd2, 2'd1);
        checks++; if (wr_bresp !== 2'b00) $display("FAIL wrap_fill_b: got %b expected 00", wr_bresp); else passed++;
        do_read(6'h02, 32'h38, 4'd3, 3'd2, 2'd2, 1'b0);
        checks++; if (rd_cnt != 4 || rd_data[0] !== 32'hC || rd_data[1] !== 32'hD || rd_data[2] !== 32'hA || rd_data[3] !== 32'hB)
            $display("FAIL wrap_order: cnt=%0d %h %h %h %h expected 4 c d a b", rd_cnt, rd_data[0], rd_data[1], rd_data[2], rd_data[3]); else passed++;
        checks++; if (rd_cycles != 4) $display("FAIL wrap_no_bubble: cycles=%0d expected 4", rd_cycles); else passed++;
    endtask

    task automatic test_strobe();
        prep_write(0);
        wr_data[0] = 32'hFFFFFFFF;
        do_write(6'h03, 32'h80, 4'd0, 3'd2, 2'd1);
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'b0101;
        do_write(6'h03, 32'h80, 4'd0, 3'd2, 2'd1);
        do_read(6'h03, 32'h80, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_data[0] !== 32'hFF22FF44) $display("FAIL strobe: got %h expected ff22ff44", rd_data[0]); else passed++;
    endtask

    task automatic test_decerr();
        prep_write(0);
        wr_data[0] = 32'h12345678;
        do_write(6'h04, 32'h0, 4'd0, 3'd2, 2'd1);
        wr_data[0] = 32'hBADBAD00;
        do_write(6'h06, 32'h1000, 4'd0, 3'd2, 2'd1);
        checks++; if (wr_bresp !== 2'b11 || wr_bid !== 6'h06) $display("FAIL decerr_b: bresp=%b bid=%h expected 11 06", wr_bresp, wr_bid); else passed++;
        do_read(6'h04, 32'h0, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_data[0] !== 32'h12345678) $display("FAIL decerr_mem: got %h expected 12345678", rd_data[0]); else passed++;
        do_read(6'h07, 32'h1000, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_resp[0] !== 2'b11 || rd_data[0] !== 32'd0) $display("FAIL decerr_r: resp=%b data=%h expected 11 0", rd_resp[0], rd_data[0]); else passed++;
    endtask

    task automatic test_slverr();
        prep_write(0);
        wr_data[0] = 32'h55AA55AA;
        do_write(6'h08, 32'h84, 4'd0, 3'd2, 2'd1);
        wr_data[0] = 32'hCAFEF00D;
        do_write(6'h09, 32'h84, 4'd0, 3'd1, 2'd1);
        checks++; if (wr_bresp !== 2'b10) $display("FAIL slverr_size_b: got %b expected 10", wr_bresp); else passed++;
        do_read(6'h08, 32'h84, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_data[0] !== 32'h55AA55AA) $display("FAIL slverr_mem: got %h expected 55aa55aa", rd_data[0]); else passed++;
        do_read(6'h0A, 32'h84, 4'd1, 3'd2, 2'd3, 1'b0);
        checks++; if (rd_cnt != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10 || rd_data[0] !== 32'd0 || rd_data[1] !== 32'd0 || rd_last[1] !== 1'b1)
            $display("FAIL slverr_r: cnt=%0d resp=%b/%b data=%h/%h last=%b expected 2 10/10 0/0 1", rd_cnt, rd_resp[0], rd_resp[1], rd_data[0], rd_data[1], rd_last[1]); else passed++;
    endtask

    task automatic test_wlast_err();
        prep_write(1);
        wr_data[0] = 32'h1; wr_data[1] = 32'h2; wr_last[0] = 1'b1;
        do_write(6'h0B, 32'h90, 4'd1, 3'd2, 2'd1);
        checks++; if (wr_beats != 2 || wr_bok !== 1'b1 || wr_bresp !== 2'b10) $display("FAIL wlast_early: beats=%0d ok=%b bresp=%b expected 2 1 10", wr_beats, wr_bok, wr_bresp); else passed++;
        prep_write(0);
        wr_last[0] = 1'b0;
        do_write(6'h0C, 32'h94, 4'd0, 3'd2, 2'd1);
        checks++; if (wr_bresp !== 2'b10) $display("FAIL wlast_missing: bresp=%b expected 10", wr_bresp); else passed++;
    endtask

    task automatic test_reset_mid_read();
        int n;
        s_arid = 6'h0D; s_araddr = 32'h40; s_arlen = 4'd7; s_arsize = 3'd2; s_arburst = 2'd1;
        s_rready = 1'b0; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin cyc(); n++; end
        cyc();
        s_arvalid = 1'b0;
        checks++; if (s_rvalid !== 1'b1) $display("FAIL midrst_pre: rvalid=%b expected 1", s_rvalid); else passed++;
        rstn = 1'b1;
        cyc();
        checks++; if (s_rvalid !== 1'b0 || s_arready !== 1'b1) $display("FAIL midrst_post: rvalid=%b arready=%b expected 0 1", s_rvalid, s_arready); else passed++;
        rstn = 1'b0;
        cyc();
        do_read(6'h0E, 32'h40, 4'd0, 3'd2, 2'd1, 1'b0);
        checks++; if (rd_cnt != 1 || rd_data[0] !== 32'h1 || rd_id[0] !== 6'h0E) $display("FAIL midrst_recover: cnt=%0d data=%h id=%h expected 1 1 0e", rd_cnt, rd_data[0], rd_id[0]); else passed++;
    endtask

    initial begin
        rstn = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd2; s_awburst = 2'd1; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd2; s_arburst = 2'd1; s_arvalid = 1'b0;
        s_rready = 1'b0;
        test_reset();
        test_single();
        test_incr_stall();
        test_wrap();
        test_strobe();
        test_decerr();
        test_slverr();
        test_wlast_err();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI memory slave endpoint for one NOC slave port (one of S0-S6).
- Consumes the write and read bursts that master-side traffic (M0-M3) delivers through the NOC, with the interconnect-extended 6-bit IDs.
- Stores data in an internal word array and returns B and R responses.
- Used as the default slave model/endpoint in the NOC environment.

Parameters:
ID_W, 6, response/request ID width (4-bit master ID + 2-bit master index)
BASE_ADDR, 32'h0000_0000, first byte address owned by this slave
MEM_WORDS, 1024, depth of 32-bit word array (power of 2)

Ports:
clk  in  1  clock, all logic on posedge
rstn  in  1  reset; synchronous, active-high (asserted = 1)
s_awid / s_arid  in  ID_W  request IDs
s_awaddr / s_araddr  in  32  byte start addresses
s_awlen / s_arlen  in  4  beats-1 (1..16 beats)
s_awsize / s_arsize  in  3  beat size; only 3'd2 (4 bytes) legal
s_awburst / s_arburst  in  2  0=FIXED 1=INCR 2=WRAP 3=reserved
s_awvalid, s_arvalid  in  1  address valid; s_awready, s_arready out 1
s_wdata  in  32  write data; s_wstrb in 4 byte strobes; s_wlast in 1
s_wvalid  in  1  write valid; s_wready out 1
s_bid  out  ID_W  echoed AWID; s_bresp out 2; s_bvalid out 1; s_bready in 1
s_rid  out  ID_W  echoed ARID; s_rdata out 32; s_rresp out 2
s_rlast  out  1  final read beat; s_rvalid out 1; s_rready in 1

Behaviour:
- Reset (rstn=1 at posedge): all FSMs to IDLE. awready=arready=1, wready=bvalid=rvalid=rlast=0, bid=rid=0, bresp=rresp=0, rdata=0. Memory contents are not cleared. Reset mid-burst abandons the burst with no response.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE; runs independently of the read FSM.
- W_IDLE: awready=1. AW handshake latches id, addr, len, burst and error flag; awready drops next cycle.
- W_DATA: wready=1. Each W handshake writes the strobed bytes to the current beat address, then advances the address.
- Burst ends on beat len+1 regardless of wlast. Error (SLVERR) if wlast=0 on the final beat or wlast=1 on any earlier beat.
- W_RESP: bvalid=1 with bid and bresp, held stable until bready. Back to W_IDLE in the cycle after the B handshake, so min 1-cycle gap before the next AW.
- Read FSM R_IDLE -> R_DATA -> R_IDLE. AR handshake latches the request.
- rvalid asserts the cycle after the AR handshake; rdata is registered.
- rvalid/rdata/rresp/rlast stay stable while rready=0. Beats issue back-to-back with no bubble while rready=1.
- rlast=1 on beat len+1. Return to R_IDLE (arready=1) in the cycle after the last R handshake.
- Address sequence (word addressing, addr[1:0] ignored):
  - FIXED: same word every beat.
  - INCR: +4 per beat, wraps modulo MEM_WORDS inside the window.
  - WRAP: wraps at the (len+1)*4-aligned boundary; len must be 1, 3, 7 or 15.
- Decode: offset = addr - BASE_ADDR, checked per beat. Out of window (offset >= MEM_WORDS*4) gives DECERR (2'b11). The write is dropped; a read returns rdata=0.
- Illegal request (size != 2, burst == 3, or WRAP with a bad len) gives SLVERR (2'b10):
  - writes: all beats are still accepted, none is committed;
  - reads: every beat returns SLVERR with rdata=0.
- bresp priority: DECERR > SLVERR > OKAY, taken as the worst over all beats. rresp is reported per beat.
- Same-word read and write in the same cycle: the read returns the pre-write data.

Test Plan:
- Single write 0x10 data 0xDEADBEEF strb F, id 6'h05, then read 0x10 -> bresp=0 bid=05; rdata=DEADBEEF, rlast=1, rid=05.
- INCR len=3 write at 0x40 (data 1,2,3,4), then read back with rready toggling 1,0,1,0 -> beats 1..4 in order; rvalid/rdata stable while stalled.
- WRAP len=3 read at 0x38 after filling 0x30..0x3C with A,B,C,D -> beats C,D,A,B.
- Write strb 4'b0101 data 0x11223344 over 0xFFFFFFFF -> readback 0xFF22FF44.
- Write to BASE_ADDR+MEM_WORDS*4 -> bresp=DECERR, memory unchanged. Write with awsize=1 -> bresp=SLVERR.
- INCR len=1 write with wlast=1 on beat 0 -> two beats accepted, bresp=SLVERR. Reset asserted mid-read burst -> rvalid=0 next cycle, arready=1.
